cpt_dec8: RTL and testbench

Loadable binary down-counter: the counting-down counterpart of the `cpt_bin8` up-counter, built from the same flip-flop library. It loads a start value, decrements once per enabled clock edge, and flags terminal count. With `reload_en` set, it restarts from the stored start value instead of stopping. It serves as the timeout and countdown primitive next to `cpt_bin8` in the `compteur` directory.

---
 rtl/cpt_dec8.sv | 62 ++++++
 tb/tb_cpt_dec8.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/cpt_dec8.sv
// Loadable down-counter with terminal-count pulse and optional auto-reload from the last loaded value.
// Priority per edge: load, terminal count, decrement, hold; never wraps below zero.
module cpt_dec8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             activate,
  input  logic             load,
  input  logic [WIDTH-1:0] init,
  input  logic             reload_en,
  output logic [WIDTH-1:0] cpt,
  output logic             zero,
  output logic             done
);

  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cpt_q, cpt_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic             done_q, done_d;

  always_comb begin
    cpt_d   = cpt_q;
    start_d = start_q;
    done_d  = 1'b0;
    if (load) begin
      cpt_d   = init;
      start_d = init;
    end else if (activate) begin
      if (cpt_q == CNT_ONE) begin
        cpt_d  = CNT_ZERO;
        done_d = 1'b1;
      end else if (cpt_q == CNT_ZERO) begin
        // A zero start value would reload to zero forever, so it simply holds.
        if (reload_en && (start_q != CNT_ZERO)) begin
          cpt_d = start_q;
        end
      end else begin
        cpt_d = cpt_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpt_q   <= '0;
      start_q <= '0;
      done_q  <= 1'b0;
    end else begin
      cpt_q   <= cpt_d;
      start_q <= start_d;
      done_q  <= done_d;
    end
  end

  assign cpt  = cpt_q;
  assign zero = (cpt_q == CNT_ZERO);
  assign done = done_q;

endmodule

// File: tb/tb_cpt_dec8.sv
// Bench for cpt_dec8: directed stimulus with expected values queued per edge and compared after it.
module tb_cpt_dec8;

  logic       clk;
  logic       reset;
  logic       activate;
  logic       load;
  logic [7:0] init;
  logic       reload_en;
  logic [7:0] cpt;
  logic       zero;
  logic       done;

  typedef struct packed {
    logic [7:0] cpt;
    logic       zero;
    logic       done;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk;
  int   n_err;
  int   n_done;

  cpt_dec8 #(.WIDTH(8)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .activate  (activate),
    .load      (load),
    .init      (init),
    .reload_en (reload_en),
    .cpt       (cpt),
    .zero      (zero),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one edge worth of inputs, queue the expected result, compare after the edge.
  task automatic step(input logic act, input logic ld, input logic [7:0] ini, input logic rel,
                      input logic [7:0] ec, input logic ed, input string tag);
    exp_t e;
    activate  = act;
    load      = ld;
    init      = ini;
    reload_en = rel;
    sb_q.push_back(exp_t'{cpt: ec, zero: (ec == 8'd0), done: ed});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({tag, "_cpt"},  {24'd0, cpt}, {24'd0, e.cpt});
    chk({tag, "_zero"}, {31'd0, zero}, {31'd0, e.zero});
    chk({tag, "_done"}, {31'd0, done}, {31'd0, e.done});
    if (done === 1'b1) n_done++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk     = 0;
    n_err     = 0;
    n_done    = 0;
    reset     = 1'b1;
    activate  = 1'b0;
    load      = 1'b0;
    init      = 8'd0;
    reload_en = 1'b0;

    // Asynchronous reset with no clock edge in the window.
    #1 reset = 1'b0;
    #2;
    chk("rst_cpt",  {24'd0, cpt}, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    step(1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, "hold0");
    step(1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, "hold1");

    // Basic countdown from 5, then stays at zero.
    step(1'b0, 1'b1, 8'd5, 1'b0, 8'd5, 1'b0, "ld5");
    for (int i = 4; i >= 0; i--)
      step(1'b1, 1'b0, 8'd0, 1'b0, 8'(i), (i == 0), "dn5");
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, "stay0");

    // Auto-reload from 3: period of 4 enabled edges.
    step(1'b0, 1'b1, 8'd3, 1'b1, 8'd3, 1'b0, "ld3");
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] ev;
      ev = 8'(2 - (i % 4));
      if ((i % 4) == 3) ev = 8'd3;
      step(1'b1, 1'b0, 8'd0, 1'b1, ev, ((i % 4) == 2), "rld");
    end
    chk("rld_pulses", n_done, 32'd2);

    // Full range down to zero, then no underflow.
    step(1'b0, 1'b1, 8'd255, 1'b0, 8'd255, 1'b0, "ld255");
    n_done = 0;
    for (int i = 254; i >= 0; i--)
      step(1'b1, 1'b0, 8'd0, 1'b0, 8'(i), (i == 0), "full");
    for (int i = 0; i < 10; i++)
      step(1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, "nounder");
    chk("full_pulses", n_done, 32'd1);

    // Pause at 1, then load collides with terminal count.
    step(1'b0, 1'b1, 8'd2, 1'b0, 8'd2, 1'b0, "ld2");
    step(1'b1, 1'b0, 8'd0, 1'b0, 8'd1, 1'b0, "to1");
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 8'd0, 1'b0, 8'd1, 1'b0, "pause");
    step(1'b1, 1'b1, 8'd7, 1'b0, 8'd7, 1'b0, "collide");

    // Load of zero never produces a terminal count.
    step(1'b0, 1'b1, 8'd0, 1'b0, 8'd0, 1'b0, "ld0");
    step(1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, "ld0act");

    // done clears even with activate dropped.
    step(1'b0, 1'b1, 8'd1, 1'b0, 8'd1, 1'b0, "ld1");
    step(1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, "tc1");
    step(1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, "doneclr");

    // Reset mid-count clears the stored start value.
    step(1'b0, 1'b1, 8'd50, 1'b1, 8'd50, 1'b0, "ld50");
    for (int i = 49; i >= 40; i--)
      step(1'b1, 1'b0, 8'd0, 1'b1, 8'(i), 1'b0, "to40");
    reset = 1'b0;
    #1;
    chk("mrst_cpt",  {24'd0, cpt}, 32'd0);
    chk("mrst_zero", {31'd0, zero}, 32'd1);
    chk("mrst_done", {31'd0, done}, 32'd0);
    #1 reset = 1'b1;
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 8'd0, 1'b1, 8'd0, 1'b0, "nostart");

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
